dm_cache_ctrl: RTL and testbench
================================

DM_CACHE_CTRL -- requirements
Module: dm_cache_ctrl

Interface
REQ-001 Parameter ADDR_W, default 16, is the word-address width for both the CPU side and the memory side.
REQ-002 Parameter DATA_W, default 16, is the data word width.
REQ-003 Parameter LINE_WORDS, default 4, is the number of words per line; it SHALL be a power of 2 and at least 2.
REQ-004 Parameter NUM_SETS, default 8, is the number of lines; it SHALL be a power of 2 and at least 2.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 re  in  1  CPU read request.
REQ-008 we  in  1  CPU write request; if re and we are both high, the access is a write.
REQ-009 addr  in  ADDR_W  CPU word address.
REQ-010 wrt_data  in  DATA_W  CPU write data.
REQ-011 rd_data  out  DATA_W  read data, valid when rdy=1 and re=1.
REQ-012 rdy  out  1  access complete this cycle; low means the pipeline stalls.
REQ-013 mem_req  out  1  backing-memory word request.
REQ-014 mem_we  out  1  1 = write-back word, 0 = fill read.
REQ-015 mem_addr  out  ADDR_W  backing-memory word address.
REQ-016 mem_wdata  out  DATA_W  write-back data.
REQ-017 mem_rdata  in  DATA_W  fill data, sampled when mem_ack=1.
REQ-018 mem_ack  in  1  current word accepted or returned; any latency of at least 1 cycle is allowed.

Function
REQ-019 Address split SHALL be: offset = addr[log2(LINE_WORDS)-1:0]; index = the next log2(NUM_SETS) bits; tag = the remaining upper bits.
REQ-020 Organisation SHALL be direct-mapped, write-back, write-allocate, with per-line valid bit, dirty bit and tag.
REQ-021 Hit (valid and tag match, FSM in IDLE) SHALL give rdy=1 combinationally in the same cycle; rd_data comes combinationally from the data array.
REQ-022 Write hit SHALL update the word and set dirty at the clock edge ending the rdy=1 cycle.
REQ-023 With re=we=0, rdy SHALL be 1 and no state SHALL change.
REQ-024 Miss SHALL give rdy=0; the CPU holds re, we, addr and wrt_data stable until rdy=1.
REQ-025 FSM states are IDLE, WRBACK and FILL.
REQ-026 IDLE on a miss SHALL go to WRBACK if the victim line is valid and dirty, otherwise to FILL.
REQ-027 WRBACK SHALL issue LINE_WORDS writes at {victim tag, index, k}, k ascending from 0, each held on mem_req/mem_addr/mem_wdata until mem_ack, then go to FILL.
REQ-028 FILL SHALL issue LINE_WORDS reads at {req tag, index, k}, k ascending from 0, writing mem_rdata into the line on each mem_ack.
REQ-029 After the last FILL ack, FILL SHALL set valid and the new tag, clear dirty, and return to IDLE; the access then hits on the next cycle, for a minimum miss latency of 1 + LINE_WORDS x (ack latency) cycles.
REQ-030 The word counter SHALL wrap to 0 on each state change, and mem_req SHALL be 0 in IDLE.

Reset
REQ-031 Reset SHALL clear all valid and dirty bits, set the FSM to IDLE, clear the counter, and force mem_req=0 and mem_we=0 immediately (asynchronously).
REQ-032 Reset mid-WRBACK or mid-FILL SHALL abandon the transfer, leaving that line invalid.
REQ-033 The data array is not reset; after reset, rdy follows REQ-021 and REQ-023.

Configuration
REQ-034 With DM_CACHE_STATS_EN defined, the block SHALL add outputs hit_cnt and miss_cnt (32 bits each, reset to 0, saturating).
REQ-035 With the macro defined, hit_cnt SHALL increment once per completed access that hit initially, and miss_cnt once per IDLE-to-miss transition.
REQ-036 Without the macro, the ports and counters SHALL be absent.

Structure
REQ-037 A shared package SHALL hold the FSM state enum, the default parameter constants and the address-split width functions.
REQ-038 A sub-module dm_cache_tag_array SHALL hold valid, dirty and tag storage with asynchronous clear; the data array stays in dm_cache_ctrl.

Verification (defaults; memory model acks 1 cycle after mem_req unless stated)
REQ-039 Read 0x0040 after reset -> rdy=0, reads 0x0040..0x0043, then rdy=1 with rd_data=mem[0x0040]; immediate re-read -> rdy=1 in the same cycle, no mem_req.
REQ-040 Write 0xBEEF to 0x0041 after REQ-039 -> rdy=1 in the same cycle; read 0x0041 -> 0xBEEF, no memory traffic.
REQ-041 Read 0x0440 (index 0, tag 0x22) -> writes to 0x0040..0x0043 with 0xBEEF at 0x0041, then reads 0x0440..0x0443, then rdy=1.
REQ-042 mem_ack delayed 3 cycles per word -> rdy=0 and mem_addr stable throughout each wait; miss completes after 13 or more cycles.
REQ-043 rst_n low during FILL word 2 -> mem_req=0 immediately; after release, read of the same address misses again.
REQ-044 With DM_CACHE_STATS_EN defined, run REQ-039 to REQ-041 -> hit_cnt=3, miss_cnt=2.

Source files
------------

// File: rtl/dm_cache_ctrl_pkg.sv
// Shared definitions for the direct-mapped cache controller: FSM state encoding,
// default geometry constants and the address-split width helpers.
package dm_cache_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WRBACK = 2'd1,
    S_FILL   = 2'd2
  } state_e;

  localparam int unsigned DEF_ADDR_W     = 16;
  localparam int unsigned DEF_DATA_W     = 16;
  localparam int unsigned DEF_LINE_WORDS = 4;
  localparam int unsigned DEF_NUM_SETS   = 8;
  localparam int unsigned STAT_W         = 32;

  // Word-offset field width
  function automatic int unsigned off_bits(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  // Set-index field width
  function automatic int unsigned idx_bits(input int unsigned num_sets);
    return $clog2(num_sets);
  endfunction

  // Tag field width: whatever address bits remain above index and offset
  function automatic int unsigned tag_bits(input int unsigned addr_w,
                                           input int unsigned line_words,
                                           input int unsigned num_sets);
    return addr_w - off_bits(line_words) - idx_bits(num_sets);
  endfunction

endpackage

// File: rtl/dm_cache_ctrl_tag_array.sv
// Per-line valid, dirty and tag storage for the direct-mapped cache.
// Valid and dirty bits clear asynchronously; tags are plain storage.
module dm_cache_tag_array
  import dm_cache_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SETS = DEF_NUM_SETS,
  parameter int unsigned TAG_W    = 9
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [idx_bits(NUM_SETS)-1:0] idx_i,
  output logic                          valid_o,
  output logic                          dirty_o,
  output logic [TAG_W-1:0]              tag_o,
  input  logic                          set_dirty_i,
  input  logic                          fill_i,
  input  logic [TAG_W-1:0]              fill_tag_i
);

  logic [NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0] dirty_q;
  logic [TAG_W-1:0]    tag_q [NUM_SETS];

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];

  // Line status: a completed fill installs a clean valid line, a write hit dirties it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (set_dirty_i) begin
      dirty_q[idx_i] <= 1'b1;
    end
  end

  // Tag storage, written only when a fill completes
  always_ff @(posedge clk) begin
    if (fill_i) begin
      tag_q[idx_i] <= fill_tag_i;
    end
  end

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller with a word-serial
// backing-memory port. Optional hit/miss counters are enabled by defining
// DM_CACHE_STATS_EN.
module dm_cache_ctrl
  import dm_cache_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
  parameter int unsigned NUM_SETS   = DEF_NUM_SETS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              re,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wrt_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rdy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
`ifdef DM_CACHE_STATS_EN
  ,
  output logic [STAT_W-1:0] hit_cnt,
  output logic [STAT_W-1:0] miss_cnt
`endif
);

  localparam int unsigned OFF_W = off_bits(LINE_WORDS);
  localparam int unsigned IDX_W = idx_bits(NUM_SETS);
  localparam int unsigned TAG_W = tag_bits(ADDR_W, LINE_WORDS, NUM_SETS);
  localparam int unsigned DEPTH = LINE_WORDS * NUM_SETS;

  logic [OFF_W-1:0]  req_off;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;

  state_e            state_q, state_d;
  logic [OFF_W-1:0]  cnt_q, cnt_d;

  logic              line_valid, line_dirty;
  logic [TAG_W-1:0]  line_tag;
  logic              access, hit, wr_hit, fill_ack, fill_last;

  logic [DATA_W-1:0] data_q [DEPTH];

  assign req_off = addr[OFF_W-1:0];
  assign req_idx = addr[OFF_W +: IDX_W];
  assign req_tag = addr[ADDR_W-1 -: TAG_W];

  assign access    = re | we;
  assign hit       = (state_q == S_IDLE) && line_valid && (line_tag == req_tag);
  assign rdy       = !access || hit;
  assign wr_hit    = we && hit;
  assign rd_data   = data_q[{req_idx, req_off}];
  assign fill_ack  = (state_q == S_FILL) && mem_ack;
  assign fill_last = fill_ack && (cnt_q == '1);

  dm_cache_tag_array #(
    .NUM_SETS (NUM_SETS),
    .TAG_W    (TAG_W)
  ) u_tags (
    .clk         (clk),
    .rst_n       (rst_n),
    .idx_i       (req_idx),
    .valid_o     (line_valid),
    .dirty_o     (line_dirty),
    .tag_o       (line_tag),
    .set_dirty_i (wr_hit),
    .fill_i      (fill_last),
    .fill_tag_i  (req_tag)
  );

  // Data array: CPU write hits and fill returns; never reset
  always_ff @(posedge clk) begin
    if (wr_hit) begin
      data_q[{req_idx, req_off}] <= wrt_data;
    end else if (fill_ack) begin
      data_q[{req_idx, cnt_q}] <= mem_rdata;
    end
  end

  // FSM state and word counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: miss dispatch, word-by-word line transfer, wrap on state change
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (access && !hit) begin
          state_d = (line_valid && line_dirty) ? S_WRBACK : S_FILL;
        end
      end
      S_WRBACK: begin
        if (mem_ack) begin
          if (cnt_q == '1) begin
            state_d = S_FILL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_FILL: begin
        if (mem_ack) begin
          if (cnt_q == '1) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Memory port: victim tag addresses write-back, request tag addresses fill
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      S_WRBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {line_tag, req_idx, cnt_q};
        mem_wdata = data_q[{req_idx, cnt_q}];
      end
      S_FILL: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, req_idx, cnt_q};
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

`ifdef DM_CACHE_STATS_EN
  logic [STAT_W-1:0] hit_cnt_q, miss_cnt_q;
  logic              miss_pend_q;

  // The hit that ends a miss belongs to that miss, so it is not counted as a hit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      miss_pend_q <= 1'b0;
    end else if (state_q == S_IDLE && access) begin
      if (!hit) begin
        miss_pend_q <= 1'b1;
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
      end else begin
        miss_pend_q <= 1'b0;
        if (!miss_pend_q && hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
      end
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Bench for dm_cache_ctrl: word-serial memory model with configurable ack
// latency, CPU-view shadow memory, and a queue of expected memory transactions.
module tb_dm_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        re, we;
  logic [15:0] addr, wrt_data, rd_data;
  logic        rdy;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic [15:0] mem_rdata = 16'h0;
  logic        mem_ack = 1'b0;
`ifdef DM_CACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        w;
    logic [15:0] a;
    logic [15:0] d;
  } xact_t;

  xact_t       exp_q[$];
  xact_t       obs_q[$];
  logic [15:0] mem_model [0:65535];
  logic [15:0] cpu_mem   [0:65535];
  int          ack_lat  = 1;
  int          wcnt     = 0;
  int          unstable = 0;
  logic [15:0] held_addr = 16'h0;

  dm_cache_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .re        (re),
    .we        (we),
    .addr      (addr),
    .wrt_data  (wrt_data),
    .rd_data   (rd_data),
    .rdy       (rdy),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
`ifdef DM_CACHE_STATS_EN
    ,
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pat(input logic [15:0] a);
    return a ^ 16'hA5C3;
  endfunction

  // Memory model: acks ack_lat cycles into each word request, logs every word
  always @(negedge clk) begin
    xact_t x;
    if (mem_ack) begin
      mem_ack = 1'b0;
      wcnt    = 0;
    end
    if (rst_n && mem_req) begin
      if (wcnt > 0 && mem_addr !== held_addr) unstable++;
      held_addr = mem_addr;
      wcnt++;
      if (wcnt >= ack_lat) begin
        mem_ack = 1'b1;
        if (mem_we) begin
          mem_model[mem_addr] = mem_wdata;
          x = '{w: 1'b1, a: mem_addr, d: mem_wdata};
        end else begin
          mem_rdata = mem_model[mem_addr];
          x = '{w: 1'b0, a: mem_addr, d: 16'h0};
        end
        obs_q.push_back(x);
      end
    end else begin
      wcnt = 0;
    end
  end

  task automatic push_fill(input logic [15:0] base);
    for (int k = 0; k < 4; k++) exp_q.push_back('{w: 1'b0, a: base + 16'(k), d: 16'h0});
  endtask

  task automatic push_wb(input logic [15:0] base);
    for (int k = 0; k < 4; k++) exp_q.push_back('{w: 1'b1, a: base + 16'(k), d: cpu_mem[base + 16'(k)]});
  endtask

  task automatic do_access(input logic w, input logic [15:0] a, input logic [15:0] d,
                           output int stall, output logic [15:0] rdv, output logic tmo);
    re = !w; we = w; addr = a; wrt_data = d;
    stall = 0; tmo = 1'b0;
    @(negedge clk);
    while (!rdy && stall < 300) begin
      stall++;
      @(negedge clk);
    end
    if (!rdy) tmo = 1'b1;
    rdv = rd_data;
    @(posedge clk); #1;
    re = 1'b0; we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; re = 1'b0; we = 1'b0; addr = '0; wrt_data = '0;
    #1;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%b want=0", mem_req); end
    total++; if (mem_we !== 1'b0)  begin bad++; $display("FAIL rst_mem_we got=%b want=0", mem_we); end
    total++; if (rdy !== 1'b1)     begin bad++; $display("FAIL rst_rdy got=%b want=1", rdy); end
`ifdef DM_CACHE_STATS_EN
    total++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin
      bad++; $display("FAIL rst_stats got=%0d/%0d want=0/0", hit_cnt, miss_cnt);
    end
`endif
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_read_miss_then_hit();
    int st; logic [15:0] rv; logic to; xact_t e, o;
    push_fill(16'h0040);
    do_access(1'b0, 16'h0040, 16'h0, st, rv, to);
    total++; if (to || st != 5) begin bad++; $display("FAIL miss_stall got=%0d tmo=%b want=5", st, to); end
    total++; if (rv !== cpu_mem[16'h0040]) begin bad++; $display("FAIL miss_rdata got=%h want=%h", rv, cpu_mem[16'h0040]); end
    do_access(1'b0, 16'h0040, 16'h0, st, rv, to);
    total++; if (to || st != 0) begin bad++; $display("FAIL rehit_stall got=%0d want=0", st); end
    total++; if (rv !== cpu_mem[16'h0040]) begin bad++; $display("FAIL rehit_rdata got=%h want=%h", rv, cpu_mem[16'h0040]); end
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL miss_xcount got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL miss_xact got=%b/%h/%h want=%b/%h/%h", o.w, o.a, o.d, e.w, e.a, e.d); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_write_hit();
    int st; logic [15:0] rv; logic to;
    do_access(1'b1, 16'h0041, 16'hBEEF, st, rv, to);
    cpu_mem[16'h0041] = 16'hBEEF;
    total++; if (to || st != 0) begin bad++; $display("FAIL wrhit_stall got=%0d want=0", st); end
    do_access(1'b0, 16'h0041, 16'h0, st, rv, to);
    total++; if (to || st != 0) begin bad++; $display("FAIL wrrd_stall got=%0d want=0", st); end
    total++; if (rv !== 16'hBEEF) begin bad++; $display("FAIL wrrd_rdata got=%h want=beef", rv); end
    total++; if (obs_q.size() != 0) begin bad++; $display("FAIL wrhit_traffic got=%0d want=0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_evict_dirty();
    int st; logic [15:0] rv; logic to; xact_t e, o;
    push_wb(16'h0040);
    push_fill(16'h0440);
    do_access(1'b0, 16'h0440, 16'h0, st, rv, to);
    total++; if (to || st != 9) begin bad++; $display("FAIL evict_stall got=%0d want=9", st); end
    total++; if (rv !== cpu_mem[16'h0440]) begin bad++; $display("FAIL evict_rdata got=%h want=%h", rv, cpu_mem[16'h0440]); end
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL evict_xcount got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL evict_xact got=%b/%h/%h want=%b/%h/%h", o.w, o.a, o.d, e.w, e.a, e.d); end
    end
    exp_q.delete(); obs_q.delete();
`ifdef DM_CACHE_STATS_EN
    total++; if (hit_cnt !== 32'd3) begin bad++; $display("FAIL stats_hit got=%0d want=3", hit_cnt); end
    total++; if (miss_cnt !== 32'd2) begin bad++; $display("FAIL stats_miss got=%0d want=2", miss_cnt); end
`endif
  endtask

  task automatic test_slow_ack();
    int st; logic [15:0] rv; logic to; xact_t e, o;
    ack_lat = 3; unstable = 0;
    push_fill(16'h0050);
    do_access(1'b0, 16'h0052, 16'h0, st, rv, to);
    total++; if (to || st != 13) begin bad++; $display("FAIL slow_stall got=%0d want=13", st); end
    total++; if (rv !== cpu_mem[16'h0052]) begin bad++; $display("FAIL slow_rdata got=%h want=%h", rv, cpu_mem[16'h0052]); end
    total++; if (unstable != 0) begin bad++; $display("FAIL slow_addr_stable got=%0d changes want=0", unstable); end
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL slow_xcount got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL slow_xact got=%b/%h/%h want=%b/%h/%h", o.w, o.a, o.d, e.w, e.a, e.d); end
    end
    exp_q.delete(); obs_q.delete();
    ack_lat = 1;
  endtask

  task automatic test_write_miss_back_to_back();
    int st; logic [15:0] rv; logic to; xact_t e, o;
    push_fill(16'h1234);
    do_access(1'b1, 16'h1235, 16'h1357, st, rv, to);
    cpu_mem[16'h1235] = 16'h1357;
    total++; if (to || st != 5) begin bad++; $display("FAIL wmiss_stall got=%0d want=5", st); end
    do_access(1'b0, 16'h1235, 16'h0, st, rv, to);
    total++; if (rv !== 16'h1357 || st != 0) begin bad++; $display("FAIL wmiss_rd got=%h/%0d want=1357/0", rv, st); end
    push_wb(16'h1234);
    push_fill(16'h2234);
    do_access(1'b0, 16'h2237, 16'h0, st, rv, to);
    total++; if (to || st != 9) begin bad++; $display("FAIL wmiss_evict_stall got=%0d want=9", st); end
    total++; if (rv !== cpu_mem[16'h2237]) begin bad++; $display("FAIL wmiss_evict_rdata got=%h want=%h", rv, cpu_mem[16'h2237]); end
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL wmiss_xcount got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL wmiss_xact got=%b/%h/%h want=%b/%h/%h", o.w, o.a, o.d, e.w, e.a, e.d); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid_fill();
    int st; int n; logic [15:0] rv; logic to; xact_t e, o;
    re = 1'b1; we = 1'b0; addr = 16'h0880;
    n = 0;
    @(negedge clk);
    while (!(mem_req && !mem_we && mem_addr == 16'h0882) && n < 50) begin
      n++;
      @(negedge clk);
    end
    total++; if (n >= 50) begin bad++; $display("FAIL midfill_reach got=timeout want=word2"); end
    #2 rst_n = 1'b0; re = 1'b0;
    #1;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL midfill_req got=%b want=0", mem_req); end
    total++; if (mem_we !== 1'b0)  begin bad++; $display("FAIL midfill_we got=%b want=0", mem_we); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.delete(); obs_q.delete();
    push_fill(16'h0880);
    do_access(1'b0, 16'h0880, 16'h0, st, rv, to);
    total++; if (to || st != 5) begin bad++; $display("FAIL postrst_stall got=%0d want=5", st); end
    total++; if (rv !== cpu_mem[16'h0880]) begin bad++; $display("FAIL postrst_rdata got=%h want=%h", rv, cpu_mem[16'h0880]); end
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL postrst_xcount got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); total++;
      if (o !== e) begin bad++; $display("FAIL postrst_xact got=%b/%h/%h want=%b/%h/%h", o.w, o.a, o.d, e.w, e.a, e.d); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem_model[i] = pat(16'(i));
      cpu_mem[i]   = pat(16'(i));
    end
    test_reset();
    test_read_miss_then_hit();
    test_write_hit();
    test_evict_dirty();
    test_slow_ack();
    test_write_miss_back_to_back();
    test_reset_mid_fill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
